// File: rtl/lu_recompose_pkg.sv
// ---------------------------------------------------------------------------
// lu_pkg
// Shared definitions for the LU recomposition block: default element width,
// matrix geometry, diagonal element indices, the controller state encoding
// and a row/column to row-major index helper.
// ---------------------------------------------------------------------------
package lu_pkg;

  // Default signed width of one incoming L/U element
  localparam int DEF_DATA_W = 3;

  // Matrix geometry: N x N matrix, NN elements streamed row-major
  localparam int N  = 3;
  localparam int NN = N * N;

  // Narrow copies used for comparisons against the small counters
  localparam logic [3:0] LAST_ELEM = 4'(NN - 1);
  localparam logic [1:0] LAST_RC   = 2'(N - 1);

  // Row-major positions of the diagonal elements U[0][0], U[1][1], U[2][2]
  localparam logic [3:0] DIAG0 = 4'd0;
  localparam logic [3:0] DIAG1 = 4'd4;
  localparam logic [3:0] DIAG2 = 4'd8;

  typedef enum logic [2:0] {
    IDLE,
    COLLECT,
    MAC,
    OUT,
    SING
  } state_t;

  // Row-major element index of (row, col) in an N x N matrix
  function automatic logic [3:0] rc_idx(input logic [1:0] row, input logic [1:0] col);
    return ({2'b00, row} * 4'd3) + {2'b00, col};
  endfunction

endpackage

// File: rtl/lu_recompose_if.sv
// ---------------------------------------------------------------------------
// lu_recompose_if
// Bundles the upstream L/U element stream and the downstream P stream of the
// LU recomposition block.
//   in_valid, invertible, decomposable : upstream beat qualifiers
//   in_l, in_u                         : signed L/U element, row-major
//   out_valid, out_singular            : output beat / singular indication
//   out_data                           : signed P element, row-major
//   out_det                            : signed U diagonal product
// Modports:
//   master : the producer/observer side (drives the in_* signals)
//   slave  : the recomposition block itself
// ---------------------------------------------------------------------------
interface lu_recompose_if #(
  parameter int DATA_W = lu_pkg::DEF_DATA_W,
  parameter int OUT_W  = 2 * DATA_W + 2,
  parameter int DET_W  = 3 * DATA_W
);

  logic                     in_valid;
  logic                     invertible;
  logic                     decomposable;
  logic signed [DATA_W-1:0] in_l;
  logic signed [DATA_W-1:0] in_u;

  logic                     out_valid;
  logic                     out_singular;
  logic signed [OUT_W-1:0]  out_data;
  logic signed [DET_W-1:0]  out_det;

  modport master (
    output in_valid, invertible, decomposable, in_l, in_u,
    input  out_valid, out_singular, out_data, out_det
  );

  modport slave (
    input  in_valid, invertible, decomposable, in_l, in_u,
    output out_valid, out_singular, out_data, out_det
  );

endinterface

// File: rtl/lu_recompose_mac.sv
// ---------------------------------------------------------------------------
// lu_mac
// Signed multiply-accumulate shared by every step of the 3x3 recomposition.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : perform one accumulate step this cycle
//   clr        : with en, the step's result is consumed by the caller and the
//                accumulator restarts from zero for the next dot product
//   a, b       : signed operands (DATA_W bits)
//   sum        : combinational acc + a*b, valid in the step it is requested
// ---------------------------------------------------------------------------
module lu_mac #(
  parameter int DATA_W = 3,
  parameter int OUT_W  = 2 * DATA_W + 2
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     en,
  input  logic                     clr,
  input  logic signed [DATA_W-1:0] a,
  input  logic signed [DATA_W-1:0] b,
  output logic signed [OUT_W-1:0]  sum
);

  logic signed [2*DATA_W-1:0] a_ext;
  logic signed [2*DATA_W-1:0] b_ext;
  logic signed [2*DATA_W-1:0] prod;
  logic signed [OUT_W-1:0]    acc_q;
  logic signed [OUT_W-1:0]    acc_d;

  // Operands are sign-extended to the full product width so the truncated
  // product is the exact two's-complement result.
  always_comb begin
    a_ext = {{DATA_W{a[DATA_W-1]}}, a};
    b_ext = {{DATA_W{b[DATA_W-1]}}, b};
    prod  = a_ext * b_ext;
    sum   = acc_q + {{(OUT_W - 2 * DATA_W){prod[2*DATA_W-1]}}, prod};
    acc_d = acc_q;
    if (en) begin
      acc_d = clr ? '0 : sum;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else begin
      acc_q <= acc_d;
    end
  end

endmodule

// File: rtl/lu_recompose.sv
// ---------------------------------------------------------------------------
// lu_recompose
// Captures a 9-beat serial L/U element stream from the LU decomposition
// stage, recomputes P = L*U with one time-shared multiply-accumulate
// (27 steps, k innermost) and streams P back out row-major over 9 beats.
// A singular upstream beat is forwarded as a one-cycle out_singular pulse.
// Ports:
//   clk, rst_n : clock, asynchronous active-low reset
//   bus        : lu_recompose_if.slave (input stream, output stream)
// Optional feature:
//   LU_RECOMPOSE_DET_EN - when defined, out_det carries U[0]*U[4]*U[8]
//   during all output beats; otherwise out_det is tied to zero and no
//   diagonal multiplier exists.
// All outputs are registered and reset to zero.
// ---------------------------------------------------------------------------
module lu_recompose
  import lu_pkg::*;
#(
  parameter int DATA_W = DEF_DATA_W,
  parameter int OUT_W  = 2 * DATA_W + 2,
  parameter int DET_W  = 3 * DATA_W
) (
  input logic           clk,
  input logic           rst_n,
  lu_recompose_if.slave bus
);

  state_t state_q, state_d;

  // cnt counts stored beats in COLLECT and emitted beats in OUT
  logic [3:0] cnt_q, cnt_d;
  logic [1:0] i_q, i_d;
  logic [1:0] j_q, j_d;
  logic [1:0] k_q, k_d;

  logic signed [DATA_W-1:0] l_q [NN];
  logic signed [DATA_W-1:0] l_d [NN];
  logic signed [DATA_W-1:0] u_q [NN];
  logic signed [DATA_W-1:0] u_d [NN];
  logic signed [OUT_W-1:0]  p_q [NN];
  logic signed [OUT_W-1:0]  p_d [NN];

  logic                    out_valid_q, out_valid_d;
  logic                    out_singular_q, out_singular_d;
  logic signed [OUT_W-1:0] out_data_q, out_data_d;

  logic                     mac_en;
  logic                     mac_clr;
  logic signed [DATA_W-1:0] mac_a;
  logic signed [DATA_W-1:0] mac_b;
  logic signed [OUT_W-1:0]  mac_sum;

  // Operand selection for the current (i, j, k) step: L[i][k] * U[k][j]
  always_comb begin
    mac_a = l_q[rc_idx(i_q, k_q)];
    mac_b = u_q[rc_idx(k_q, j_q)];
  end

  lu_mac #(
    .DATA_W (DATA_W),
    .OUT_W  (OUT_W)
  ) u_mac (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (mac_en),
    .clr   (mac_clr),
    .a     (mac_a),
    .b     (mac_b),
    .sum   (mac_sum)
  );

  // Controller: next state, counters, storage updates and output values.
  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    i_d            = i_q;
    j_d            = j_q;
    k_d            = k_q;
    l_d            = l_q;
    u_d            = u_q;
    p_d            = p_q;
    out_valid_d    = 1'b0;
    out_singular_d = 1'b0;
    out_data_d     = '0;
    mac_en         = 1'b0;
    mac_clr        = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (bus.in_valid && bus.invertible && bus.decomposable) begin
          l_d[0]  = bus.in_l;
          u_d[0]  = bus.in_u;
          cnt_d   = 4'd1;
          state_d = COLLECT;
        end else if (bus.in_valid && !bus.invertible) begin
          state_d = SING;
        end
      end

      COLLECT: begin
        if (bus.in_valid) begin
          l_d[cnt_q] = bus.in_l;
          u_d[cnt_q] = bus.in_u;
          if (cnt_q == LAST_ELEM) begin
            cnt_d   = '0;
            i_d     = '0;
            j_d     = '0;
            k_d     = '0;
            state_d = MAC;
          end else begin
            cnt_d = cnt_q + 4'd1;
          end
        end else begin
          // Short matrix: drop it silently
          cnt_d   = '0;
          state_d = IDLE;
        end
      end

      MAC: begin
        mac_en = 1'b1;
        if (k_q == LAST_RC) begin
          // Dot product complete: capture it and restart the accumulator
          mac_clr               = 1'b1;
          p_d[rc_idx(i_q, j_q)] = mac_sum;
          k_d                   = '0;
          if (j_q == LAST_RC) begin
            j_d = '0;
            if (i_q == LAST_RC) begin
              i_d     = '0;
              cnt_d   = '0;
              state_d = OUT;
            end else begin
              i_d = i_q + 2'd1;
            end
          end else begin
            j_d = j_q + 2'd1;
          end
        end else begin
          k_d = k_q + 2'd1;
        end
      end

      OUT: begin
        out_valid_d = 1'b1;
        out_data_d  = p_q[cnt_q];
        if (cnt_q == LAST_ELEM) begin
          cnt_d   = '0;
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SING: begin
        out_valid_d    = 1'b1;
        out_singular_d = 1'b1;
        state_d        = IDLE;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q        <= IDLE;
      cnt_q          <= '0;
      i_q            <= '0;
      j_q            <= '0;
      k_q            <= '0;
      l_q            <= '{default: '0};
      u_q            <= '{default: '0};
      p_q            <= '{default: '0};
      out_valid_q    <= 1'b0;
      out_singular_q <= 1'b0;
      out_data_q     <= '0;
    end else begin
      state_q        <= state_d;
      cnt_q          <= cnt_d;
      i_q            <= i_d;
      j_q            <= j_d;
      k_q            <= k_d;
      l_q            <= l_d;
      u_q            <= u_d;
      p_q            <= p_d;
      out_valid_q    <= out_valid_d;
      out_singular_q <= out_singular_d;
      out_data_q     <= out_data_d;
    end
  end

  assign bus.out_valid    = out_valid_q;
  assign bus.out_singular = out_singular_q;
  assign bus.out_data     = out_data_q;

`ifdef LU_RECOMPOSE_DET_EN
  logic                    det_load;
  logic signed [DET_W-1:0] u0_ext, u4_ext, u8_ext;
  logic signed [DET_W-1:0] det_q, det_d;
  logic signed [DET_W-1:0] out_det_q, out_det_d;

  // The determinant is latched on the final MAC step so it is ready for the
  // first OUT beat; it is presented only while OUT beats are emitted.
  always_comb begin
    det_load  = (state_q == MAC) && (i_q == LAST_RC) && (j_q == LAST_RC) && (k_q == LAST_RC);
    u0_ext    = {{(DET_W - DATA_W){u_q[DIAG0][DATA_W-1]}}, u_q[DIAG0]};
    u4_ext    = {{(DET_W - DATA_W){u_q[DIAG1][DATA_W-1]}}, u_q[DIAG1]};
    u8_ext    = {{(DET_W - DATA_W){u_q[DIAG2][DATA_W-1]}}, u_q[DIAG2]};
    det_d     = det_q;
    if (det_load) begin
      det_d = u0_ext * u4_ext * u8_ext;
    end
    out_det_d = (state_q == OUT) ? det_q : '0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      det_q     <= '0;
      out_det_q <= '0;
    end else begin
      det_q     <= det_d;
      out_det_q <= out_det_d;
    end
  end

  assign bus.out_det = out_det_q;
`else
  assign bus.out_det = {DET_W{1'b0}};
`endif

endmodule

// File: tb/tb_lu_recompose.sv
// ---------------------------------------------------------------------------
// tb_lu_recompose
// Randomized, scoreboard-checked bench for lu_recompose. Stimulus tasks push
// the expected output beats (value, singular flag, determinant and the clock
// edge count at which each beat must appear) into a queue; an independent
// monitor pops and compares whenever out_valid is seen.
// ---------------------------------------------------------------------------
module tb_lu_recompose;

  typedef struct {
    bit sing;
    int data;
    int det;
    int cyc;
  } exp_t;

  logic clk;
  logic rst_n;
  int   cycleCount;
  int   compared;
  int   mismatched;
  exp_t sb[$];

  lu_recompose_if bus ();

  lu_recompose dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Edge counter used to timestamp expected output beats
  initial cycleCount = 0;
  always @(posedge clk) cycleCount <= cycleCount + 1;

  // One comparison: counted, and reported if it does not hold
  task automatic checkOutput(input string name, input longint actual, input longint expected);
    compared++;
    if (actual != expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // Reference model: plain matrix product P = L*U and the U diagonal product
  function automatic int refP(input int lm[9], input int um[9], input int n);
    int r, c, s;
    r = n / 3;
    c = n % 3;
    s = 0;
    for (int k = 0; k < 3; k++) s += lm[r*3 + k] * um[k*3 + c];
    return s;
  endfunction

  function automatic int refDet(input int um[9]);
`ifdef LU_RECOMPOSE_DET_EN
    return um[0] * um[4] * um[8];
`else
    return (um[0] == 12345) ? 1 : 0;
`endif
  endfunction

  // Monitor: every valid output beat must match the next queued expectation
  always @(negedge clk) begin
    if (bus.out_valid === 1'b1) begin
      if (sb.size() == 0) begin
        compared++;
        mismatched++;
        $display("[TB] FAIL unexpected_beat: got out_data=%0d, expected no out_valid (t=%0t)",
                 bus.out_data, $time);
      end else begin
        exp_t e;
        int   actData, actDet;
        e       = sb.pop_front();
        actData = bus.out_data;
        actDet  = bus.out_det;
        checkOutput("out_data", actData, e.data);
        checkOutput("out_singular", bus.out_singular, e.sing);
        checkOutput("out_det", actDet, e.det);
        checkOutput("beat_cycle", cycleCount, e.cyc);
      end
    end
  end

  // Drive nbeats consecutive beats and queue what the DUT must produce
  task automatic applyStimulus(input int lm[9], input int um[9], input int nbeats,
                               input bit inv, input bit dec);
    int   lastEdge;
    exp_t e;
    lastEdge = 0;
    for (int b = 0; b < nbeats; b++) begin
      @(negedge clk);
      bus.in_valid     = 1'b1;
      bus.invertible   = inv;
      bus.decomposable = dec;
      bus.in_l         = 3'(lm[b]);
      bus.in_u         = 3'(um[b]);
      lastEdge         = cycleCount + 1;
    end
    if (!inv) begin
      e.sing = 1'b1;
      e.data = 0;
      e.det  = 0;
      e.cyc  = lastEdge + 1;
      sb.push_back(e);
    end else if (dec && nbeats == 9) begin
      for (int n = 0; n < 9; n++) begin
        e.sing = 1'b0;
        e.data = refP(lm, um, n);
        e.det  = refDet(um);
        e.cyc  = lastEdge + 28 + n;
        sb.push_back(e);
      end
    end
    @(negedge clk);
    bus.in_valid     = 1'b0;
    bus.invertible   = 1'b0;
    bus.decomposable = 1'b0;
    bus.in_l         = '0;
    bus.in_u         = '0;
  endtask

  // Bounded wait for all queued beats to be seen and out_valid to drop
  task automatic waitDrain(input string name);
    int n;
    n = 0;
    while ((sb.size() != 0 || bus.out_valid === 1'b1) && n < 200) begin
      @(negedge clk);
      n++;
    end
    if (n >= 200) begin
      checkOutput({name, "_drain_timeout"}, sb.size(), 0);
      sb.delete();
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic checkZeroOutputs(input string tag);
    int d, t;
    d = bus.out_data;
    t = bus.out_det;
    checkOutput({tag, "_valid"}, bus.out_valid, 0);
    checkOutput({tag, "_singular"}, bus.out_singular, 0);
    checkOutput({tag, "_data"}, d, 0);
    checkOutput({tag, "_det"}, t, 0);
  endtask

  task automatic genRandom(output int lm[9], output int um[9]);
    for (int n = 0; n < 9; n++) begin
      lm[n] = int'($urandom_range(0, 7)) - 4;
      um[n] = int'($urandom_range(0, 7)) - 4;
    end
  endtask

  // Watchdog so the run always ends
  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: got no finish, expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int idL[9], lL[9], lU[9], nU[9], rl[9], ru[9];
    int kind;
    idL = '{1, 0, 0, 0, 1, 0, 0, 0, 1};
    lL  = '{1, 0, 0, 1, 1, 0, 0, 1, 1};
    lU  = '{1, 1, 0, 0, 1, 1, 0, 0, 1};
    nU  = '{1, 1, 1, 0, -1, 0, 0, 0, -4};
    compared   = 0;
    mismatched = 0;

    rst_n            = 1'b0;
    bus.in_valid     = 1'b0;
    bus.invertible   = 1'b0;
    bus.decomposable = 1'b0;
    bus.in_l         = '0;
    bus.in_u         = '0;
    repeat (3) @(negedge clk);
    checkZeroOutputs("reset");
    #1 rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] identity");
    applyStimulus(idL, idL, 9, 1'b1, 1'b1);
    waitDrain("identity");

    $display("[TB] lower/upper");
    applyStimulus(lL, lU, 9, 1'b1, 1'b1);
    waitDrain("lower_upper");

    $display("[TB] negative values");
    applyStimulus(idL, nU, 9, 1'b1, 1'b1);
    waitDrain("negative");

    $display("[TB] singular beat");
    applyStimulus(idL, idL, 1, 1'b0, 1'b1);
    waitDrain("singular");

    $display("[TB] non-decomposable beat is ignored");
    applyStimulus(idL, idL, 1, 1'b1, 1'b0);
    repeat (40) @(negedge clk);

    $display("[TB] abort after 5 beats");
    applyStimulus(idL, idL, 5, 1'b1, 1'b1);
    repeat (40) @(negedge clk);
    applyStimulus(idL, idL, 9, 1'b1, 1'b1);
    waitDrain("after_abort");

    $display("[TB] reset during MAC");
    genRandom(rl, ru);
    applyStimulus(rl, ru, 9, 1'b1, 1'b1);
    repeat (10) @(posedge clk);
    #2 rst_n = 1'b0;
    sb.delete();
    #1 checkZeroOutputs("mac_rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    genRandom(rl, ru);
    applyStimulus(rl, ru, 9, 1'b1, 1'b1);
    waitDrain("after_mac_rst");

    $display("[TB] reset during output beats");
    genRandom(rl, ru);
    applyStimulus(rl, ru, 9, 1'b1, 1'b1);
    repeat (31) @(posedge clk);
    #2 checkOutput("pre_rst_valid", bus.out_valid, 1);
    rst_n = 1'b0;
    sb.delete();
    #1 checkZeroOutputs("out_rst");
    repeat (2) @(negedge clk);
    #1 rst_n = 1'b1;
    applyStimulus(lL, lU, 9, 1'b1, 1'b1);
    waitDrain("after_out_rst");

    $display("[TB] randomized matrices");
    for (int t = 0; t < 30; t++) begin
      genRandom(rl, ru);
      kind = int'($urandom_range(0, 9));
      if (kind == 0) begin
        applyStimulus(rl, ru, 1, 1'b0, 1'($urandom_range(0, 1)));
        waitDrain("rand_sing");
      end else if (kind == 1) begin
        applyStimulus(rl, ru, int'($urandom_range(1, 8)), 1'b1, 1'b1);
        repeat (40) @(negedge clk);
      end else begin
        applyStimulus(rl, ru, 9, 1'b1, 1'b1);
        waitDrain("rand_full");
      end
    end

    repeat (40) @(negedge clk);
    checkOutput("queue_empty", sb.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

// File: doc/lu_recompose.md
# lu_recompose

Downstream consumer of the 3x3 LU decomposition stage. It captures the serial L/U element stream, recomputes P = L·U with a single time-shared multiply-accumulate, and streams P back out row-major for self-checking against the original binary matrix. Singular results (invertible=0) are forwarded as a one-cycle flag. An optional determinant output (product of the U diagonal) can be compiled in.

## Interface
- DATA_W, 3: signed width of each incoming L/U element.
- OUT_W, 2*DATA_W+2: signed width of each P element and of the accumulator.
- DET_W, 3*DATA_W: signed width of out_det.
- clk  in  1  clock.
- rst_n  in  1  reset; asynchronous, active-low.
- in_valid  in  1  upstream beat valid. Up to 9 consecutive beats per matrix.
- invertible  in  1  upstream invertible flag, sampled with in_valid.
- decomposable  in  1  upstream decomposable flag, sampled with in_valid.
- in_l  in  DATA_W  signed L element, row-major index 0..8.
- in_u  in  DATA_W  signed U element, row-major index 0..8.
- out_valid  out  1  output beat valid.
- out_singular  out  1  singular-matrix indication.
- out_data  out  OUT_W  signed P element, row-major.
- out_det  out  DET_W  signed U0·U4·U8; held for all 9 output beats.

## Operation
- Reset value of every output is 0. State resets to IDLE; all counters reset to 0.
- IDLE:
  - On in_valid & invertible & decomposable: store beat 0 and go to COLLECT.
  - On in_valid & !invertible: go to SING.
  - Otherwise stay in IDLE.
- COLLECT: store L[idx] and U[idx] each cycle while in_valid=1.
  - After beat 8 is stored, go to MAC.
  - If in_valid drops before beat 8: discard the matrix, return to IDLE, emit nothing.
- MAC: 27 cycles. Counters i (row), j (column) and k each run 0..2, with k innermost.
  - acc += sext(L[3i+k]) * sext(U[3k+j]).
  - At k=2, write P[3i+j] and clear acc.
  - After (i,j,k)=(2,2,2), go to OUT.
- OUT: 9 cycles. out_valid=1 and out_data=P[n] for n=0..8. Then go to IDLE.
- SING: one cycle. out_valid=1, out_singular=1, out_data=0, out_det=0. Then go to IDLE.
- Arithmetic:
  - All operations are signed two's complement.
  - Each product is 2*DATA_W bits; the 3-term sum fits in OUT_W with no saturation or overflow handling.
- in_valid is ignored in MAC, OUT and SING. Upstream never overlaps matrices.
- Reset mid-operation: outputs are 0 immediately (asynchronous), and the partial matrix is lost.

## Timing
- All outputs are registered.
- Let beat 8 be sampled at edge E. MAC occupies E+1..E+27. out_valid is first high after edge E+28 and stays high for exactly 9 consecutive cycles.
- Total input-to-first-output latency is 28 cycles after the last input beat.
- Singular case: out_valid is high for the single cycle after the edge following the sampled singular beat.
- A new matrix is accepted in IDLE on the cycle after out_valid falls.

## Configuration
- LU_RECOMPOSE_DET_EN defined:
  - out_det = U[0]*U[4]*U[8], computed once when entering OUT.
  - out_det is valid during all OUT beats and is 0 otherwise.
- LU_RECOMPOSE_DET_EN not defined:
  - out_det is tied to 0.
  - No diagonal multiplier is instantiated.

## Structure
- Package lu_pkg holds:
  - DATA_W default.
  - State enum {IDLE, COLLECT, MAC, OUT, SING}.
  - Matrix-size constant N=3 and element count NN=9.
  - Diagonal index constants 0, 4, 8.
- One sub-module, lu_mac: a signed multiply-accumulate with a clear input. It is shared by all 27 MAC steps.

## Test plan
- Identity test: L=I, U=I, 9 beats.
  - Expected P = 1,0,0,0,1,0,0,0,1.
  - Expected det=1 (with DET_EN).
- Lower/upper test: L=[1 0 0;1 1 0;0 1 1], U=[1 1 0;0 1 1;0 0 1].
  - Expected P = 1,1,0,1,2,1,0,1,2, det=1.
  - first out_valid exactly 28 cycles after beat 8.
- Negative-value test: L=I, U=[1 1 1;0 -1 0;0 0 -4].
  - Expected P = 1,1,1,0,-1,0,0,0,-4, det=4 (sign-extension check).
- Singular beat: in_valid=1, invertible=0.
  - Expected exactly one cycle of out_valid=1, out_singular=1, out_data=0. Then IDLE.
- Abort: in_valid drops after 5 beats.
  - Expected no out_valid.
  - A following full identity matrix then produces the correct identity output.
- Reset mid-operation: rst_n pulsed low during MAC cycle 10.
  - Expected: all outputs 0, state IDLE.
  - The next matrix is processed correctly.
